clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
Parametrised, runtime-programmable clock/strobe generator that replaces the fixed divide-by-constant toggler. It is used to derive sample clocks (e.g. 50 kHz ADC pacing from the 125 MHz system clock). It adds programmable period and duty cycle, a valid/ready config handshake with glitch-free application at period boundaries, enable gating, phase resync, and one-cycle rise/fall strobes.

Parameters:
CNT_W, 32, width of counter, period and high-time fields
DEF_PERIOD, 2500, period in clk cycles after reset (125 MHz / 2500 = 50 kHz)
DEF_HIGH, 1250, high time in clk cycles after reset (50 % duty)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low holds the generator idle
sync  in  1  one-cycle phase-resync request
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  generator can accept a configuration
cfg_period  in  CNT_W  requested period P in clk cycles
cfg_high  in  CNT_W  requested high time H in clk cycles
clk_out  out  1  divided clock, registered
rise_tick  out  1  one-cycle strobe in the cycle clk_out goes 1
fall_tick  out  1  one-cycle strobe in the cycle clk_out goes 0
cur_period  out  CNT_W  period currently in effect (after clamping)

Behaviour:
- Reset (async, rst_n=0): cnt=0, running=0, clk_out=0, rise_tick=0, fall_tick=0, active P=DEF_PERIOD, active H=DEF_HIGH, pending empty, cfg_ready=1, cur_period=DEF_PERIOD. Reset deassertion is taken synchronously; the first edge with rst_n=1 behaves as an idle cycle.
- Clamping is applied when a configuration is accepted: P<2 becomes 2; H=0 becomes 1; H>=P becomes P-1. The output therefore always toggles. Arithmetic is unsigned CNT_W.
- Idle (running=0): cnt=0, clk_out=0, and both ticks are 0.
- Start: at the first edge where en=1 and running=0: running<=1, cnt<=0, clk_out<=1, rise_tick<=1.
- Running, each edge with en=1:
  - cnt_n = (cnt==P-1) ? 0 : cnt+1
  - cnt<=cnt_n; clk_out<=(cnt_n<H); rise_tick<=(cnt_n==0); fall_tick<=(cnt_n==H)
  - Result: clk_out is high for H cycles and low for P-H cycles, with period exactly P.
- en falls while running: at the next edge running<=0, cnt<=0, clk_out<=0, ticks<=0. If clk_out was 1, fall_tick<=1 in that cycle, so every rise is paired with a fall.
- Config handshake: a configuration is accepted at an edge where cfg_valid=1 and cfg_ready=1. The clamped values go to the pending register and cfg_ready<=0.
  - While running, pending is applied at the wrap edge (cnt_n==0). The new P/H govern the period that starts there. cur_period updates at that edge, then cfg_ready<=1 on the following edge.
  - While idle, pending is applied at the next edge.
  - Only one pending configuration exists; cfg_valid is ignored while cfg_ready=0.
- Simultaneous wrap and accept on the same edge: the accepted configuration is not applied at that wrap. It waits for the next wrap.
- sync=1 while running: cnt<=0, clk_out<=1, rise_tick<=1 at that edge, and any pending configuration is applied there. If clk_out was already 1, there is no extra fall_tick.
- sync while idle is ignored. sync together with en falling: the en-fall behaviour wins.
- rise_tick and fall_tick are never both 1, because H is always between 1 and P-1.

Test Plan:
- Reset, then en=1 with defaults -> first clk_out=1 one edge after en is sampled; high 1250 cycles, low 1250 cycles, rise_tick every 2500 cycles; cur_period=2500.
- cfg P=5, H=2 accepted mid-period of P=10/H=5 -> old period finishes intact; then pattern 11000 repeats; cfg_ready low from accept until one edge after the wrap.
- cfg P=1, H=0 -> clamped to P=2, H=1; clk_out alternates 1,0; cur_period=2.
- cfg P=8, H=9 -> H clamped to 7; clk_out high 7 cycles, low 1 cycle; fall_tick once per 8 cycles.
- sync pulse at cnt=3 with P=10/H=5 -> clk_out=1 and rise_tick=1 at the next edge, new period of 10 starts; pending config applied at the sync edge.
- en dropped while clk_out=1, then rst_n pulsed low mid-period -> fall_tick=1 once and clk_out=0; async reset clears all outputs immediately without waiting for clk and restores P=2500, H=1250.

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable divided clock / strobe generator.
// Produces a registered clk_out with programmable period and high time,
// one-cycle rise/fall strobes, enable gating and phase resync.
//
// Config handshake (valid/ready): a configuration transfers on a clk edge
// where cfg_valid and cfg_ready are both 1. The clamped values are held
// in a single pending slot, and cfg_ready stays low while the slot is full.
// The slot is applied at a period boundary: a wrap, a sync, or any edge
// while idle. cfg_ready returns high on the edge after the slot is applied.
module clk_div_gen #(
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 2500,
    parameter int unsigned DEF_HIGH   = 1250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] cur_period
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] act_p;
    logic [CNT_W-1:0] act_h;
    logic [CNT_W-1:0] pend_p;
    logic [CNT_W-1:0] pend_h;
    logic [CNT_W-1:0] clamp_p;
    logic [CNT_W-1:0] clamp_h;
    logic             pend_full;
    logic             ready_dly;
    logic             running;
    logic             wrap;
    logic             apply;
    logic             accept;

    // Next-count, boundary detection and clamping of the offered configuration.
    always_comb begin
        wrap    = (cnt == act_p - CNT_W'(1));
        cnt_n   = wrap ? '0 : cnt + CNT_W'(1);
        accept  = cfg_valid && cfg_ready;
        // A pending config lands at any boundary: idle edge, sync or wrap.
        // When en falls while running it waits one edge, until idle.
        apply   = pend_full && (!running || (en && (sync || wrap)));
        clamp_p = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        clamp_h = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
        if (clamp_h >= clamp_p) begin
            clamp_h = clamp_p - CNT_W'(1);
        end
    end

    // Waveform generator: counter, divided clock and edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            running   <= 1'b0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else if (!running) begin
            cnt       <= '0;
            fall_tick <= 1'b0;
            if (en) begin
                running   <= 1'b1;
                clk_out   <= 1'b1;
                rise_tick <= 1'b1;
            end else begin
                clk_out   <= 1'b0;
                rise_tick <= 1'b0;
            end
        end else if (!en) begin
            // Stopping while high still emits the matching fall strobe.
            running   <= 1'b0;
            cnt       <= '0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= clk_out;
        end else if (sync) begin
            cnt       <= '0;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
            fall_tick <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            clk_out   <= (cnt_n < act_h);
            rise_tick <= (cnt_n == '0);
            fall_tick <= (cnt_n == act_h);
        end
    end

    // Configuration path: pending slot, active period/high time, ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_p     <= DEF_P;
            act_h     <= DEF_H;
            pend_p    <= DEF_P;
            pend_h    <= DEF_H;
            pend_full <= 1'b0;
            ready_dly <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            ready_dly <= apply;
            if (apply) begin
                act_p     <= pend_p;
                act_h     <= pend_h;
                pend_full <= 1'b0;
            end
            if (ready_dly) begin
                cfg_ready <= 1'b1;
            end else if (accept) begin
                cfg_ready <= 1'b0;
                pend_full <= 1'b1;
                pend_p    <= clamp_p;
                pend_h    <= clamp_h;
            end
        end
    end

    assign cur_period = act_p;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed scenarios plus randomized stimulus, compared
// every cycle against a waveform-queue reference model.
module tb_clk_div_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic [31:0] cfg_high;
    logic        clk_out;
    logic        rise_tick;
    logic        fall_tick;
    logic [31:0] cur_period;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_gen #(.CNT_W(32), .DEF_PERIOD(2500), .DEF_HIGH(1250)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .cur_period(cur_period)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an expected output waveform queue for the current period.
    bit          wq[$];
    bit          m_running;
    bit          m_out;
    bit          m_rise;
    bit          m_fall;
    bit          m_pend;
    bit          m_ready;
    bit          m_ready_dly;
    logic [31:0] m_p;
    logic [31:0] m_h;
    logic [31:0] m_pend_p;
    logic [31:0] m_pend_h;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_running   = 0;
        m_out       = 0;
        m_rise      = 0;
        m_fall      = 0;
        m_pend      = 0;
        m_ready     = 1;
        m_ready_dly = 0;
        m_p         = 2500;
        m_h         = 1250;
        m_pend_p    = 0;
        m_pend_h    = 0;
    endtask

    task automatic new_period();
        wq.delete();
        for (int i = 0; i < int'(m_p); i++) wq.push_back(i < int'(m_h));
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit          accept;
        bit          apply_now;
        bit          prev_out;
        logic [31:0] cp;
        logic [31:0] ch;
        accept    = cfg_valid && m_ready;
        apply_now = 0;
        prev_out  = m_out;
        cp = (cfg_period < 2) ? 32'd2 : cfg_period;
        ch = (cfg_high == 0) ? 32'd1 : cfg_high;
        if (ch > cp - 1) ch = cp - 1;
        if (!m_running) begin
            apply_now = m_pend;
        end else if (en && (sync || wq.size() == 0)) begin
            apply_now = m_pend;
        end
        if (apply_now) begin
            m_p    = m_pend_p;
            m_h    = m_pend_h;
            m_pend = 0;
        end
        if (!m_running) begin
            wq.delete();
            m_fall = 0;
            if (en) begin
                m_running = 1;
                new_period();
                m_out  = wq.pop_front();
                m_rise = 1;
            end else begin
                m_out  = 0;
                m_rise = 0;
            end
        end else if (!en) begin
            wq.delete();
            m_running = 0;
            m_out     = 0;
            m_rise    = 0;
            m_fall    = prev_out;
        end else if (sync || wq.size() == 0) begin
            new_period();
            m_out  = wq.pop_front();
            m_rise = 1;
            m_fall = 0;
        end else begin
            m_out  = wq.pop_front();
            m_rise = 0;
            m_fall = prev_out && !m_out;
        end
        if (m_ready_dly) begin
            m_ready = 1;
        end else if (accept) begin
            m_ready  = 0;
            m_pend   = 1;
            m_pend_p = cp;
            m_pend_h = ch;
        end
        m_ready_dly = apply_now;
    endtask

    task automatic compare_all();
        check("clk_out",    {31'b0, clk_out},   {31'b0, m_out});
        check("rise_tick",  {31'b0, rise_tick}, {31'b0, m_rise});
        check("fall_tick",  {31'b0, fall_tick}, {31'b0, m_fall});
        check("cfg_ready",  {31'b0, cfg_ready}, {31'b0, m_ready});
        check("cur_period", cur_period,         m_p);
    endtask

    // Driver: advance one clock, update model, compare after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic offer(input logic [31:0] p, input logic [31:0] h);
        int guard;
        guard = 0;
        while (!m_ready && guard < 6000) begin
            cycle();
            guard++;
        end
        check("ready_wait", {31'b0, cfg_ready}, 32'd1);
        cfg_valid  = 1;
        cfg_period = p;
        cfg_high   = h;
        cycle();
        cfg_valid  = 0;
    endtask

    initial begin
        int rises;
        int guard;
        rst_n = 0; en = 0; sync = 0; cfg_valid = 0; cfg_period = 0; cfg_high = 0;
        model_reset();
        run(3);
        #1 rst_n = 1;

        // Defaults: 2500-cycle period, 50 % duty; two rises in 5000 edges.
        run(2);
        en = 1;
        rises = 0;
        for (int i = 0; i < 5000; i++) begin
            cycle();
            rises += int'(rise_tick);
        end
        check("default_rise_count", rises, 32'd2);

        // Load P=10/H=5 while idle, start, then P=5/H=2 mid-period.
        en = 0;
        run(2);
        offer(10, 5);
        run(3);
        check("cur_p10", cur_period, 32'd10);
        en = 1;
        run(13);
        offer(5, 2);
        run(40);

        // Clamp cases.
        offer(1, 0);
        run(30);
        check("cur_p2", cur_period, 32'd2);
        offer(8, 9);
        run(40);

        // Sync with a pending configuration.
        offer(10, 5);
        run(25);
        offer(6, 3);
        run(1);
        sync = 1;
        cycle();
        sync = 0;
        check("sync_applies_cfg", cur_period, 32'd6);
        run(20);

        // Drop en while clk_out is high.
        guard = 0;
        while (!(m_out && !m_rise) && guard < 100) begin
            cycle();
            guard++;
        end
        check("high_wait", {31'b0, clk_out}, 32'd1);
        en = 0;
        cycle();
        check("en_fall_tick", {31'b0, fall_tick}, 32'd1);
        run(5);

        // Restart and assert async reset mid-period, between clock edges.
        en = 1;
        run(4);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        en = 0;
        run(3);
        #2 rst_n = 1;
        run(3);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            en         = ($urandom_range(0, 29) != 0);
            sync       = ($urandom_range(0, 19) == 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = $urandom_range(0, 12);
            cfg_high   = $urandom_range(0, 13);
            cycle();
        end
        en = 0; sync = 0; cfg_valid = 0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
